// File: rtl/actmem_bank_arbiter.sv
// actmem_bank_arbiter
// Shares the single-ported activation-memory banks among the linebuffer read
// stream, the OCU writeback path and the host port. Each requester's bank
// vector is granted all-or-nothing in the same cycle it is requested. Write
// and host requesters carry starvation counters that promote them ahead of
// the read stream once they saturate. Read data is routed back one cycle
// after grant using a registered per-bank owner tag.
//
// Handshake (all three requesters): a requester raises *_req_i with a stable
// payload and keeps both unchanged until its *_gnt_o is high; the transfer
// happens in the cycle where request and grant are both high. Grants are
// combinational in that same cycle.
module actmem_bank_arbiter #(
    parameter int NUMBANKS     = 6,
    parameter int BANKDEPTH    = 512,
    parameter int WORDWIDTH    = 104,
    parameter int STARVE_LIMIT = 8,
    parameter int AW           = $clog2(BANKDEPTH)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    // linebuffer read stream
    input  logic                                  rd_req_i,
    input  logic [0:NUMBANKS-1]                   rd_en_vec_i,
    input  logic [0:NUMBANKS-1][AW-1:0]           rd_addr_i,
    output logic                                  rd_gnt_o,
    output logic                                  rd_rvalid_o,
    output logic [0:NUMBANKS-1][WORDWIDTH-1:0]    rd_rdata_o,
    // OCU writeback
    input  logic                                  wr_req_i,
    input  logic [0:NUMBANKS-1]                   wr_en_vec_i,
    input  logic [0:NUMBANKS-1][AW-1:0]           wr_addr_i,
    input  logic [0:NUMBANKS-1][WORDWIDTH-1:0]    wr_data_i,
    output logic                                  wr_gnt_o,
    // host configuration/debug port
    input  logic                                  host_req_i,
    input  logic                                  host_we_i,
    input  logic [$clog2(NUMBANKS)-1:0]           host_bank_i,
    input  logic [AW-1:0]                         host_addr_i,
    input  logic [WORDWIDTH-1:0]                  host_wdata_i,
    output logic                                  host_gnt_o,
    output logic                                  host_rvalid_o,
    output logic [WORDWIDTH-1:0]                  host_rdata_o,
    // bank side
    output logic [0:NUMBANKS-1]                   bank_req_o,
    output logic [0:NUMBANKS-1]                   bank_we_o,
    output logic [0:NUMBANKS-1][AW-1:0]           bank_addr_o,
    output logic [0:NUMBANKS-1][WORDWIDTH-1:0]    bank_wdata_o,
    input  logic [0:NUMBANKS-1][WORDWIDTH-1:0]    bank_rdata_i
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    // Per-bank return owner tags.
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_READ = 2'd1;
    localparam logic [1:0] OWN_HOST = 2'd2;

    logic [CW-1:0]              wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]              host_cnt_q, host_cnt_d;
    logic [0:NUMBANKS-1][1:0]   owner_q, owner_d;
    logic                       rd_rvalid_q, rd_rvalid_d;
    logic                       host_rvalid_q, host_rvalid_d;

    logic [0:NUMBANKS-1]        host_vec;
    logic [0:NUMBANKS-1]        claim;
    logic                       wr_starved, host_starved;
    logic                       rd_gnt, wr_gnt, host_gnt;

    // Decode the host bank index into a one-hot vector; illegal indices touch no bank.
    always_comb begin
        host_vec = '0;
        if (32'(host_bank_i) < NUMBANKS) begin
            host_vec[host_bank_i] = 1'b1;
        end
    end

    // Claim banks in priority order; promoted (starved) requesters go first.
    always_comb begin
        wr_starved   = (wr_cnt_q == CNT_MAX);
        host_starved = (host_cnt_q == CNT_MAX);
        claim        = '0;
        rd_gnt       = 1'b0;
        wr_gnt       = 1'b0;
        host_gnt     = 1'b0;
        if (!rst_i) begin
            if (host_req_i && host_starved && ((host_vec & claim) == '0)) begin
                host_gnt = 1'b1;
                claim    = claim | host_vec;
            end
            if (wr_req_i && wr_starved && ((wr_en_vec_i & claim) == '0)) begin
                wr_gnt = 1'b1;
                claim  = claim | wr_en_vec_i;
            end
            if (rd_req_i && ((rd_en_vec_i & claim) == '0)) begin
                rd_gnt = 1'b1;
                claim  = claim | rd_en_vec_i;
            end
            if (wr_req_i && !wr_starved && ((wr_en_vec_i & claim) == '0)) begin
                wr_gnt = 1'b1;
                claim  = claim | wr_en_vec_i;
            end
            if (host_req_i && !host_starved && ((host_vec & claim) == '0)) begin
                host_gnt = 1'b1;
                claim    = claim | host_vec;
            end
        end
        rd_gnt_o   = rd_gnt;
        wr_gnt_o   = wr_gnt;
        host_gnt_o = host_gnt;
    end

    // Steer the winning payloads onto the banks and tag the owner of each read.
    always_comb begin
        bank_req_o   = '0;
        bank_we_o    = '0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        owner_d      = '0;
        for (int b = 0; b < NUMBANKS; b++) begin
            owner_d[b] = OWN_NONE;
            if (rd_gnt && rd_en_vec_i[b]) begin
                bank_req_o[b]  = 1'b1;
                bank_addr_o[b] = rd_addr_i[b];
                owner_d[b]     = OWN_READ;
            end else if (wr_gnt && wr_en_vec_i[b]) begin
                bank_req_o[b]   = 1'b1;
                bank_we_o[b]    = 1'b1;
                bank_addr_o[b]  = wr_addr_i[b];
                bank_wdata_o[b] = wr_data_i[b];
            end else if (host_gnt && host_vec[b]) begin
                bank_req_o[b]  = 1'b1;
                bank_we_o[b]   = host_we_i;
                bank_addr_o[b] = host_addr_i;
                if (host_we_i) begin
                    bank_wdata_o[b] = host_wdata_i;
                end else begin
                    owner_d[b] = OWN_HOST;
                end
            end
        end
        rd_rvalid_d   = rd_gnt;
        host_rvalid_d = host_gnt && !host_we_i;
    end

    // Starvation counters: count denied cycles, saturate, clear on grant or idle.
    always_comb begin
        wr_cnt_d   = '0;
        host_cnt_d = '0;
        if (!rst_i && wr_req_i && !wr_gnt) begin
            wr_cnt_d = wr_starved ? wr_cnt_q : wr_cnt_q + CW'(1);
        end
        if (!rst_i && host_req_i && !host_gnt) begin
            host_cnt_d = host_starved ? host_cnt_q : host_cnt_q + CW'(1);
        end
    end

    // State registers; reset drops any pending return.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt_q      <= '0;
            host_cnt_q    <= '0;
            owner_q       <= '0;
            rd_rvalid_q   <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            wr_cnt_q      <= wr_cnt_d;
            host_cnt_q    <= host_cnt_d;
            owner_q       <= owner_d;
            rd_rvalid_q   <= rd_rvalid_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    // Route the bank read data to whichever requester owned each bank last cycle.
    always_comb begin
        rd_rdata_o    = '0;
        host_rdata_o  = '0;
        for (int b = 0; b < NUMBANKS; b++) begin
            if (owner_q[b] == OWN_READ) begin
                rd_rdata_o[b] = bank_rdata_i[b];
            end
            if (owner_q[b] == OWN_HOST) begin
                host_rdata_o = bank_rdata_i[b];
            end
        end
        rd_rvalid_o   = rd_rvalid_q;
        host_rvalid_o = host_rvalid_q;
    end

endmodule

// File: doc/actmem_bank_arbiter.md
# actmem_bank_arbiter

Shares the single-ported activation-memory banks among three requesters:
- the linebuffer fill stream, driven by the actmem-to-linebuffer read controller;
- the OCU writeback path;
- the host configuration/debug port.

Each requester's bank vector is granted atomically and per cycle. Starvation counters bound the wait of lower-priority requesters. Read data returns to the requester one cycle after grant.

## Interface
- NUMBANKS, 6: number of activation-memory banks (K*WEIGHT_STAGGER).
- BANKDEPTH, 512: words per bank.
- WORDWIDTH, 104: physical bits per bank word.
- STARVE_LIMIT, 8: consecutive denied cycles before a requester is promoted; must be ≥1.
- AW, $clog2(BANKDEPTH): address width.
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- rd_req_i  in  1  linebuffer read request.
- rd_en_vec_i  in  [0:NUMBANKS-1]  banks the read touches.
- rd_addr_i  in  [0:NUMBANKS-1][AW]  per-bank read address.
- rd_gnt_o  out  1  read granted this cycle.
- rd_rvalid_o  out  1  read data valid, one cycle after rd_gnt_o.
- rd_rdata_o  out  [0:NUMBANKS-1][WORDWIDTH]  per-bank read data; '0 for banks not read.
- wr_req_i  in  1  writeback request.
- wr_en_vec_i  in  [0:NUMBANKS-1]  banks the write touches.
- wr_addr_i  in  [0:NUMBANKS-1][AW]  per-bank write address.
- wr_data_i  in  [0:NUMBANKS-1][WORDWIDTH]  per-bank write data.
- wr_gnt_o  out  1  write granted this cycle.
- host_req_i  in  1  host single-word request.
- host_we_i  in  1  1 = write, 0 = read.
- host_bank_i  in  $clog2(NUMBANKS)  target bank; values ≥NUMBANKS are illegal.
- host_addr_i  in  AW  word address.
- host_wdata_i  in  WORDWIDTH  write data.
- host_gnt_o  out  1  host granted.
- host_rvalid_o  out  1  host read data valid, one cycle after a host read grant.
- host_rdata_o  out  WORDWIDTH  host read data.
- bank_req_o  out  [0:NUMBANKS-1]  bank enable.
- bank_we_o  out  [0:NUMBANKS-1]  bank write enable.
- bank_addr_o  out  [0:NUMBANKS-1][AW]  bank address.
- bank_wdata_o  out  [0:NUMBANKS-1][WORDWIDTH]  bank write data.
- bank_rdata_i  in  [0:NUMBANKS-1][WORDWIDTH]  bank read data, valid one cycle after a bank read.

## Operation
- Handshake:
  - A requester holds its request and payload stable until its grant.
  - Grants are combinational in the same cycle as the request.
  - A transfer occurs when request and grant are both high.
- Grants are all-or-nothing. A vector is granted only if none of its banks are already claimed this cycle.
- Claim order within a cycle, each step claiming its banks if they are free:
  1. Starved host.
  2. Starved write.
  3. Read.
  4. Non-starved write.
  5. Non-starved host.
- "Starved" means that requester's counter equals STARVE_LIMIT.
- Disjoint read and write vectors are both granted in the same cycle.
- A request with an all-zero vector is granted immediately and touches no bank.
  - For a read, rd_rvalid_o still pulses next cycle with all data '0.
- Starvation counters: one each for write and host, width $clog2(STARVE_LIMIT+1).
  - Increment when the request is high and the grant is low.
  - Saturate at STARVE_LIMIT.
  - Clear on grant or when the request is low.
- The read requester has no counter.
- Bank outputs drive the winning payloads. Unclaimed banks have req=0 and we=0; their addr and wdata are don't-care and are driven '0.
- Return routing: register the per-bank owner (none, read, or host) and the host bank index at grant. Route bank_rdata_i to rd_rdata_o or host_rdata_o in the next cycle.
- Host writes produce no rvalid.

## Timing
- Grant: 0-cycle latency. Read data: 1-cycle latency after grant.
- Back-to-back grants on consecutive cycles are supported without bubbles.
- Reset (rst_i=1 at a clock edge) has the following effect:
  - Counters clear to 0.
  - Return-owner registers clear to none.
  - rd_rvalid_o and host_rvalid_o are 0 in the cycle following reset.
  - rd_rdata_o and host_rdata_o are '0.
- Reset asserted mid-transaction drops the pending return; no rvalid is produced for a read granted in the reset cycle.
- While rst_i is high, all grants and bank_req_o are 0.
- Worst-case wait:
  - Write: STARVE_LIMIT+1 cycles, unless a starved host claims an overlapping bank in that cycle.
  - Host: STARVE_LIMIT+1 cycles.

## Test plan
- Disjoint access: read vec 111000 at addr 5, write vec 000111 at addr 9, same cycle -> both grants high; banks 0-2 read @5, banks 3-5 written @9; rd_rvalid_o next cycle carrying banks 0-2 data and banks 3-5 = 0.
- Write starvation: read vec 111111 every cycle, write vec 000001 held, STARVE_LIMIT=8 -> wr_gnt_o low for 8 cycles, high on cycle 9; rd_gnt_o low in that cycle; write counter reads 0 afterwards.
- Host priority: host read bank 2 starved while read vec 001100 and write vec 110000 are requested -> host granted; read denied; write granted; host_rvalid_o next cycle with bank 2 data.
- Zero vector: rd_req_i with vec 000000 -> immediate grant, no bank_req_o, rd_rvalid_o next cycle with data all '0.
- Reset mid-read: grant a read, assert rst_i in the same cycle -> no rd_rvalid_o next cycle; counters 0.
- Back-to-back reads at addr 0..15 over bank vectors rotating 111000/000111 -> 16 consecutive grants; data returns in order, each with 1-cycle latency.
